// File: rtl/uvc_clk_pkg.sv
// rtl/uvc_clk_pkg.sv - shared types, widths and default timings for the UVC PLL reset sequencer
package uvc_clk_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    PHY_REL   = 3'd3,
    RUN       = 3'd4,
    FAULT     = 3'd5
  } seq_state_t;

  localparam int DEF_PLL_RST_CYCLES      = 24;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 240000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 2400;
  localparam int DEF_PHY_TO_CORE_CYCLES  = 240;
  localparam int DEF_MAX_RETRIES         = 4;
  localparam int DEF_SYNC_STAGES         = 2;
  localparam int DEF_CNT_W               = 18;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  typedef struct packed {
    logic pll_reset;
    logic phy_rst_n;
    logic core_rst_n;
    logic ready;
    logic fault;
  } seq_out_t;

  localparam seq_out_t RESET_OUTS = '{
    pll_reset:  1'b1,
    phy_rst_n:  1'b0,
    core_rst_n: 1'b0,
    ready:      1'b0,
    fault:      1'b0
  };

  // Output levels owned by each state; the top registers this for the next state.
  function automatic seq_out_t decode_outputs(seq_state_t s);
    seq_out_t o;
    o = RESET_OUTS;
    case (s)
      WAIT_LOCK, STABLE: o.pll_reset = 1'b0;
      PHY_REL: begin
        o.pll_reset = 1'b0;
        o.phy_rst_n = 1'b1;
      end
      RUN: begin
        o.pll_reset  = 1'b0;
        o.phy_rst_n  = 1'b1;
        o.core_rst_n = 1'b1;
        o.ready      = 1'b1;
      end
      FAULT: o.fault = 1'b1;
      default: o = RESET_OUTS;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/uvc_pll_reset_seq_if.sv
// rtl/uvc_pll_reset_seq_if.sv - lock input, relock request and reset/status outputs of the sequencer
interface uvc_pll_reset_seq_if;
  import uvc_clk_pkg::*;

  logic              pll_lock_i;
  logic              force_relock_i;
  logic              pll_reset_o;
  logic              phy_rst_n_o;
  logic              core_rst_n_o;
  logic              ready_o;
  logic              fault_o;
  logic [RETRY_W-1:0] retry_cnt_o;
  logic [LOSS_W-1:0]  lock_loss_cnt_o;

  modport master (
    input  pll_lock_i,
    input  force_relock_i,
    output pll_reset_o,
    output phy_rst_n_o,
    output core_rst_n_o,
    output ready_o,
    output fault_o,
    output retry_cnt_o,
    output lock_loss_cnt_o
  );

  modport slave (
    output pll_lock_i,
    output force_relock_i,
    input  pll_reset_o,
    input  phy_rst_n_o,
    input  core_rst_n_o,
    input  ready_o,
    input  fault_o,
    input  retry_cnt_o,
    input  lock_loss_cnt_o
  );

endinterface

// File: rtl/uvc_bit_sync.sv
// rtl/uvc_bit_sync.sv - multi-flop synchronizer for a single asynchronous level, clears to 0
module uvc_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uvc_pll_reset_seq.sv
// rtl/uvc_pll_reset_seq.sv - PLL reset/lock sequencer releasing USB PHY then UVC core resets
// Optional lock-loss counter enabled by defining UVC_LOCK_LOSS_CNT_EN.
module uvc_pll_reset_seq
  import uvc_clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int PHY_TO_CORE_CYCLES  = DEF_PHY_TO_CORE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  uvc_pll_reset_seq_if.master bus
);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST    = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   P2C_LAST    = CNT_W'(PHY_TO_CORE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

  logic               lock_s;
  seq_state_t         state_q, state_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [RETRY_W-1:0] retry_q, retry_nxt;
  seq_out_t           out_q;
  logic               loss_event;

  uvc_bit_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.pll_lock_i),
    .q    (lock_s)
  );

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    retry_nxt  = retry_q;
    loss_event = 1'b0;
    if (bus.force_relock_i && (state_q != PLL_RST)) begin
      // A force wins over a simultaneous lock loss, so it is never counted as one.
      state_nxt = PLL_RST;
      cnt_nxt   = '0;
      retry_nxt = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          if (cnt_q == RST_LAST) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            // The edge that first sees lock already counts as the first stable high.
            state_nxt = (STB_LAST == '0) ? PHY_REL : STABLE;
            cnt_nxt   = (STB_LAST == '0) ? '0 : CNT_W'(1);
          end else if (cnt_q == TO_LAST) begin
            retry_nxt = retry_q + RETRY_W'(1);
            state_nxt = (retry_nxt == RETRY_LIMIT) ? FAULT : PLL_RST;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
            cnt_nxt   = '0;
          end else if (cnt_q >= STB_LAST) begin
            state_nxt = PHY_REL;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        PHY_REL: begin
          if (!lock_s) begin
            state_nxt = PLL_RST;
            cnt_nxt   = '0;
          end else if (cnt_q == P2C_LAST) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
            retry_nxt = '0;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_nxt  = PLL_RST;
            cnt_nxt    = '0;
            loss_event = 1'b1;
          end
        end
        FAULT: state_nxt = FAULT;
        default: begin
          state_nxt = PLL_RST;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= RESET_OUTS;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      retry_q <= retry_nxt;
      out_q   <= decode_outputs(state_nxt);
    end
  end

  assign bus.pll_reset_o  = out_q.pll_reset;
  assign bus.phy_rst_n_o  = out_q.phy_rst_n;
  assign bus.core_rst_n_o = out_q.core_rst_n;
  assign bus.ready_o      = out_q.ready;
  assign bus.fault_o      = out_q.fault;
  assign bus.retry_cnt_o  = retry_q;

`ifdef UVC_LOCK_LOSS_CNT_EN
  logic [LOSS_W-1:0] loss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loss_q <= '0;
    end else if (loss_event && (loss_q != '1)) begin
      loss_q <= loss_q + LOSS_W'(1);
    end
  end

  assign bus.lock_loss_cnt_o = loss_q;
`else
  logic loss_event_unused;

  assign loss_event_unused   = loss_event;
  assign bus.lock_loss_cnt_o = '0;
`endif

endmodule
